// File: rtl/counter_run_ctrl.sv
// rtl/counter_run_ctrl.sv - run controller owning a bounded, repeatable up/down count register
//
// Ports:
//   clk       - clock, all state on rising edge
//   rst       - asynchronous active-low reset
//   start     - run request, honoured only in IDLE
//   cfg_tc    - terminal count, latched on accepted start
//   cfg_reps  - repetition count, latched on accepted start (0 runs once)
//   cfg_down  - direction, latched on accepted start (0 = up, 1 = down)
//   hold      - freeze the run while high
//   abort     - cancel the run (wins over hold)
//   busy      - high while running
//   ctr       - current count
//   wrap      - one-cycle pulse after each non-final reload
//   done      - one-cycle pulse after the final repetition
//   rep_done  - repetitions completed in the current/last run

module counter_run_ctrl #(
    parameter int WIDTH = 3,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_tc,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic             cfg_down,
    input  logic             hold,
    input  logic             abort,
    output logic             busy,
    output logic [WIDTH-1:0] ctr,
    output logic             wrap,
    output logic             done,
    output logic [REP_W-1:0] rep_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] tc_q;
    logic [REP_W-1:0] reps_q;
    logic             down_q;

    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    logic             at_end;
    logic             last_rep;

    always_comb begin
        start_val = down_q ? tc_q : '0;
        end_val   = down_q ? '0 : tc_q;
        at_end    = (ctr == end_val);
        // reps_q is never 0 once a run is accepted, so this cannot underflow in RUN
        last_rep  = (rep_done == reps_q - REP_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            tc_q     <= '0;
            reps_q   <= '0;
            down_q   <= 1'b0;
            busy     <= 1'b0;
            ctr      <= '0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            rep_done <= '0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tc_q     <= cfg_tc;
                        reps_q   <= (cfg_reps == '0) ? REP_W'(1) : cfg_reps;
                        down_q   <= cfg_down;
                        ctr      <= cfg_down ? cfg_tc : '0;
                        rep_done <= '0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        ctr   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (hold) begin
                        // everything frozen; wrap/done already defaulted low
                    end else if (!at_end) begin
                        ctr <= down_q ? ctr - WIDTH'(1) : ctr + WIDTH'(1);
                    end else if (!last_rep) begin
                        ctr      <= start_val;
                        rep_done <= rep_done + REP_W'(1);
                        wrap     <= 1'b1;
                    end else begin
                        // final terminal: ctr parks on the end value
                        rep_done <= rep_done + REP_W'(1);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb/tb_counter_run_ctrl.sv - directed self-checking bench for counter_run_ctrl

module tb_counter_run_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] cfg_tc;
    logic [3:0] cfg_reps;
    logic       cfg_down;
    logic       hold;
    logic       abort;
    logic       busy;
    logic [2:0] ctr;
    logic       wrap;
    logic       done;
    logic [3:0] rep_done;

    int total = 0;
    int bad   = 0;
    int busy_cnt;
    int done_seen;

    counter_run_ctrl #(.WIDTH(3), .REP_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_tc   (cfg_tc),
        .cfg_reps (cfg_reps),
        .cfg_down (cfg_down),
        .hold     (hold),
        .abort    (abort),
        .busy     (busy),
        .ctr      (ctr),
        .wrap     (wrap),
        .done     (done),
        .rep_done (rep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input int e_ctr, input int e_busy,
                           input int e_wrap, input int e_done, input int e_rep);
        chk({tag, ".ctr"}, int'(ctr), e_ctr);
        chk({tag, ".busy"}, int'(busy), e_busy);
        chk({tag, ".wrap"}, int'(wrap), e_wrap);
        chk({tag, ".done"}, int'(done), e_done);
        chk({tag, ".rep_done"}, int'(rep_done), e_rep);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; cfg_tc = '0; cfg_reps = '0; cfg_down = 1'b0;
        hold = 1'b0; abort = 1'b0;
        #1;
        chk_out("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_out("idle", 0, 0, 0, 0, 0);

        // up, tc=5, two repetitions
        cfg_tc = 3'd5; cfg_reps = 4'd2; cfg_down = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk_out($sformatf("up5.c%0d", i), i % 6, 1, (i == 6) ? 1 : 0, 0, (i >= 6) ? 1 : 0);
            tick();
        end
        chk_out("up5.done", 5, 0, 0, 1, 2);
        tick();
        chk_out("up5.idle", 5, 0, 0, 0, 2);

        // down, tc=3, reps=0 runs once
        cfg_tc = 3'd3; cfg_reps = 4'd0; cfg_down = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("dn3.c%0d", i), 3 - i, 1, 0, 0, 0);
            tick();
        end
        chk_out("dn3.done", 0, 0, 0, 1, 1);
        tick();

        // up, tc=7, hold three edges at ctr=4, cfg_tc toggled mid-run
        cfg_tc = 3'd7; cfg_reps = 4'd1; cfg_down = 1'b0; start = 1'b1;
        busy_cnt = 0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hold.pre%0d", i), int'(ctr), i);
            if (busy) busy_cnt++;
            tick();
        end
        chk("hold.at4", int'(ctr), 4);
        if (busy) busy_cnt++;
        hold = 1'b1; cfg_tc = 3'd2; cfg_down = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("hold.h%0d", i), 4, 1, 0, 0, 0);
            if (busy) busy_cnt++;
        end
        hold = 1'b0;
        for (int i = 5; i <= 7; i++) begin
            tick();
            chk($sformatf("hold.post%0d", i), int'(ctr), i);
            if (busy) busy_cnt++;
        end
        tick();
        chk_out("hold.done", 7, 0, 0, 1, 1);
        chk("hold.busy_cycles", busy_cnt, 11);
        tick();

        // up, tc=6, reps=3, abort at ctr=2 in the second repetition
        cfg_tc = 3'd6; cfg_reps = 4'd3; cfg_down = 1'b0; start = 1'b1;
        done_seen = 0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("abt.c%0d", i), int'(ctr), i % 7);
            if (done) done_seen++;
            tick();
        end
        chk_out("abt.at2", 2, 1, 0, 0, 1);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk_out("abt.next", 0, 0, 0, 0, 1);
        tick();
        chk_out("abt.ignored_start", 0, 0, 0, 0, 1);
        if (done) done_seen++;
        chk("abt.no_done", done_seen, 0);

        // asynchronous reset mid-run
        cfg_tc = 3'd6; cfg_reps = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("arst.pre_ctr", int'(ctr), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.ctr", int'(ctr), 0);
        chk("arst.busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_out("arst.after", 0, 0, 0, 0, 0);

        // tc=0, reps=4: every RUN cycle is a terminal
        cfg_tc = 3'd0; cfg_reps = 4'd4; cfg_down = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("tc0.c0", 0, 1, 0, 0, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_out($sformatf("tc0.c%0d", i), 0, 1, 1, 0, i);
        end
        tick();
        chk_out("tc0.done", 0, 0, 0, 1, 4);
        tick();
        chk_out("tc0.idle", 0, 0, 0, 0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
Run controller for the 3-bit counter datapath. It owns the count register and sequences it: the count starts on request, steps up or down to a programmable terminal value, and repeats a programmed number of times. The block can be held or aborted mid-run and reports wrap and completion. It sits between a host/control FSM and the counter consumers, replacing a free-running counter where bounded, repeatable runs are needed.

Parameters:
WIDTH, 3, count width (ctr, cfg_tc)
REP_W, 4, repetition-count width (cfg_reps, rep_done)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  run request, sampled only in IDLE
cfg_tc  input  WIDTH  terminal count; latched on accepted start
cfg_reps  input  REP_W  repetitions; latched on accepted start; 0 treated as 1
cfg_down  input  1  0 = count up 0..tc, 1 = count down tc..0; latched on accepted start
hold  input  1  freeze run while 1
abort  input  1  cancel run
busy  output  1  1 while in RUN
ctr  output  WIDTH  current count
wrap  output  1  one-cycle pulse on each non-final reload
done  output  1  one-cycle pulse on completion
rep_done  output  REP_W  repetitions completed in current/last run

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - state=IDLE; ctr=0, busy=0, wrap=0, done=0, rep_done=0.
  - Internal latched config is cleared.
  - A reset mid-run discards the run; no done pulse.
- All outputs are registered.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ctr holds its last value.
  - When start=1 at an edge, latch tc, reps (0 becomes 1) and down.
  - At that same edge: ctr loads the start value (0 if up, tc if down), rep_done=0, busy=1, state=RUN.
  - start while busy, or while in DONE, is ignored.
- RUN: priority per edge is abort > hold > step.
  - abort=1: next edge goes to IDLE with ctr=0, busy=0, no wrap, no done. rep_done keeps its value.
  - hold=1 (abort=0): ctr, rep_done, state and remaining reps frozen; wrap=0. Resume is seamless on the first edge with hold=0.
  - ctr is not at end value (tc if up, 0 if down): ctr steps by 1 (+1 if up, -1 if down).
  - ctr at end value, not the final repetition:
    - ctr reloads the start value and rep_done increments.
    - wrap=1 for the following cycle.
  - ctr at end value, final repetition:
    - ctr holds the end value and rep_done increments.
    - state=DONE, busy=0, done=1 for the following cycle. wrap is not asserted.
  - One repetition lasts tc+1 unheld RUN cycles.
  - tc=0: ctr stays 0 and each RUN cycle is a terminal.
  - busy is high for (tc+1)*reps cycles plus held cycles.
- DONE: lasts exactly one cycle (done=1), then IDLE unconditionally. abort and hold are ignored.
- Config inputs changing during RUN have no effect.
- Arithmetic: ctr never leaves [0, tc]; no modular wrap beyond tc. rep_done saturates never (it is at most reps ≤ 2^REP_W-1).

Test Plan:
- Reset, then start with cfg_tc=5, cfg_reps=2, cfg_down=0:
  - ctr = 0,1,2,3,4,5,0,1,2,3,4,5 over 12 busy cycles; wrap high only on the cycle ctr returns to 0.
  - Next cycle: done=1, busy=0, ctr=5, rep_done=2. One cycle later, IDLE with done=0.
- cfg_tc=3, cfg_down=1, cfg_reps=0:
  - ctr = 3,2,1,0 over 4 busy cycles, then done; rep_done=1 (0 reps treated as 1).
- cfg_tc=7, cfg_reps=1, up, hold=1 for 3 cycles while ctr=4:
  - ctr stays 4 for 3 cycles, then continues 5,6,7; busy lasts 11 cycles.
  - Toggling cfg_tc mid-run has no effect.
- Up run with tc=6, reps=3, abort pulsed while ctr=2 in the 2nd repetition:
  - Next cycle: ctr=0, busy=0, done never asserted, rep_done=1.
  - A start pulse on the abort cycle is ignored.
- Drive rst=0 asynchronously between clock edges mid-run:
  - ctr=0, busy=0 immediately, before the next edge.
  - After release, start with tc=0, reps=4: ctr stays 0; wrap high for 3 cycles; then done=1 with rep_done=4.
